// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter unit for the RISC-V core. It holds the PC and offers it to
//   instruction memory with a valid/ready handshake. The next PC comes from one
//   of three sources: the sequential step (+2/+4), a branch/jump redirect, or
//   the trap vector. A misaligned redirect halts fetching until a trap arrives.
//
// Parameters
//   XLEN          PC/data width in bits
//   RESET_VECTOR  PC value loaded on reset
//   C_EXT         1 = 16-bit instructions allowed (2-byte alignment)
//   CNT_W         width of the accepted-fetch counter
//
// Ports
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   fetch_ready_i    instruction memory accepts pc_o this cycle
//   stall_i          pipeline hold; blocks sequential advance and branch redirect
//   inst_comp_i      current instruction is 16-bit (ignored when C_EXT=0)
//   br_taken_i       branch/jump redirect request
//   br_target_i      redirect address
//   trap_i           trap/exception entry request
//   trap_vec_i       trap handler address (bits [1:0] are dropped)
//   pc_o             current fetch address (registered)
//   pc_valid_o       pc_o is a valid fetch request
//   pc_seq_o         pc_o + step, combinational; used as the link address
//   misalign_o       one-cycle pulse on a misaligned redirect
//   misalign_addr_o  offending redirect target, held until the next one
//   fetch_cnt_o      number of accepted fetches (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             fetch_ready_i,
  input  logic             stall_i,
  input  logic             inst_comp_i,
  input  logic             br_taken_i,
  input  logic [XLEN-1:0]  br_target_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  trap_vec_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic [XLEN-1:0]  pc_seq_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  misalign_addr_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic [XLEN-1:0]  step;
  logic [XLEN-1:0]  pc_seq;
  logic [XLEN-1:0]  trap_vec_al;
  logic             br_misalign;
  logic             accept;

  // 2-byte step only exists when compressed instructions are enabled.
  assign step        = (C_EXT && inst_comp_i) ? XLEN'(2) : XLEN'(4);
  assign pc_seq      = pc_q + step;
  assign trap_vec_al = {trap_vec_i[XLEN-1:2], 2'b00};

  // Bit 1 of a target is only illegal without the compressed extension.
  assign br_misalign = br_target_i[0] | (~C_EXT & br_target_i[1]);

  // A stalled fetch is re-presented on the following cycle with the same PC,
  // so it is only counted once the pipeline actually consumes it.
  assign accept = pc_valid_q & fetch_ready_i & ~stall_i;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_valid_d      = pc_valid_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    fetch_cnt_d     = fetch_cnt_q;

    unique case (state_q)
      ST_BOOT: begin
        // Single dead cycle after reset; trap requests are not honoured here.
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end

      ST_RUN: begin
        if (accept) begin
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end

        if (trap_i) begin
          pc_d = trap_vec_al;
        end else if (br_taken_i && !stall_i) begin
          if (br_misalign) begin
            // PC stays put so the faulting instruction's address is preserved.
            misalign_d      = 1'b1;
            misalign_addr_d = br_target_i;
            pc_valid_d      = 1'b0;
            state_d         = ST_HALT;
          end else begin
            pc_d = br_target_i;
          end
        end else if (accept) begin
          pc_d = pc_seq;
        end
      end

      ST_HALT: begin
        if (trap_i) begin
          pc_d       = trap_vec_al;
          pc_valid_d = 1'b1;
          state_d    = ST_RUN;
        end
      end

      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      fetch_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      fetch_cnt_q     <= fetch_cnt_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = pc_valid_q;
  assign pc_seq_o        = pc_seq;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
  assign fetch_cnt_o     = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Two instances share one stimulus stream: dut_a is the 4-byte-aligned core
//   (C_EXT=0, 32-bit counter), dut_b the compressed variant with a 4-bit
//   counter. Every cycle both are compared against a behavioural model; the
//   directed table and hand-written sequences add fixed expected values.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fetch_ready, stall, inst_comp, br_taken, trap;
  logic [31:0] br_target, trap_vec;

  logic [31:0] a_pc, a_seq, a_maddr, a_cnt;
  logic        a_valid, a_mis;
  logic [31:0] b_pc, b_seq, b_maddr;
  logic [3:0]  b_cnt;
  logic        b_valid, b_mis;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .fetch_ready_i(fetch_ready), .stall_i(stall),
    .inst_comp_i(inst_comp), .br_taken_i(br_taken), .br_target_i(br_target),
    .trap_i(trap), .trap_vec_i(trap_vec), .pc_o(a_pc), .pc_valid_o(a_valid),
    .pc_seq_o(a_seq), .misalign_o(a_mis), .misalign_addr_o(a_maddr),
    .fetch_cnt_o(a_cnt));

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .fetch_ready_i(fetch_ready), .stall_i(stall),
    .inst_comp_i(inst_comp), .br_taken_i(br_taken), .br_target_i(br_target),
    .trap_i(trap), .trap_vec_i(trap_vec), .pc_o(b_pc), .pc_valid_o(b_valid),
    .pc_seq_o(b_seq), .misalign_o(b_mis), .misalign_addr_o(b_maddr),
    .fetch_cnt_o(b_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", nm, act, exp);
  endtask

  // ---------------- behavioural reference model (index 0 = dut_a, 1 = dut_b)
  // phase: 0 = boot cycle pending, 1 = fetching, 2 = halted on misalignment
  int          m_phase [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_maddr [2];
  logic [31:0] m_cnt   [2];
  bit          m_mis   [2];

  function automatic logic [31:0] ssize(input int d);
    return (d == 1 && inst_comp) ? 32'd2 : 32'd4;
  endfunction

  function automatic logic [31:0] cnt_wrap(input int d, input logic [31:0] v);
    return (d == 1) ? (v % 32'd16) : v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_pc[d] = 32'h0; m_maddr[d] = 32'h0;
      m_cnt[d] = 32'h0; m_mis[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    logic [31:0] align;
    align = (d == 1) ? 32'd2 : 32'd4;
    m_mis[d] = 1'b0;
    if (m_phase[d] == 0) begin
      m_phase[d] = 1;
    end else if (m_phase[d] == 1) begin
      if (fetch_ready && !stall) m_cnt[d] = cnt_wrap(d, m_cnt[d] + 32'd1);
      if (trap) begin
        m_pc[d] = trap_vec - (trap_vec % 32'd4);
      end else if (br_taken && !stall) begin
        if (br_target % align != 32'd0) begin
          m_mis[d] = 1'b1; m_maddr[d] = br_target; m_phase[d] = 2;
        end else begin
          m_pc[d] = br_target;
        end
      end else if (fetch_ready && !stall) begin
        m_pc[d] = m_pc[d] + ssize(d);
      end
    end else if (trap) begin
      m_pc[d] = trap_vec - (trap_vec % 32'd4);
      m_phase[d] = 1;
    end
  endtask

  task automatic compare_model();
    chk ("a.pc",    a_pc,    m_pc[0]);
    chk1("a.valid", a_valid, m_phase[0] == 1);
    chk1("a.mis",   a_mis,   m_mis[0]);
    chk ("a.maddr", a_maddr, m_maddr[0]);
    chk ("a.cnt",   a_cnt,   m_cnt[0]);
    chk ("b.pc",    b_pc,    m_pc[1]);
    chk1("b.valid", b_valid, m_phase[1] == 1);
    chk1("b.mis",   b_mis,   m_mis[1]);
    chk ("b.maddr", b_maddr, m_maddr[1]);
    chk ("b.cnt",   {28'd0, b_cnt}, m_cnt[1]);
  endtask

  // Inputs are set by the caller; settle, check link address, clock once.
  task automatic tick();
    #1;
    chk("a.pc_seq", a_seq, m_pc[0] + ssize(0));
    chk("b.pc_seq", b_seq, m_pc[1] + ssize(1));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; stall = 1'b0; inst_comp = 1'b0; br_taken = 1'b0;
    trap = 1'b0; br_target = 32'h0; trap_vec = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk ("rst.a.pc",    a_pc,    32'h0);
    chk1("rst.a.valid", a_valid, 1'b0);
    chk1("rst.a.mis",   a_mis,   1'b0);
    chk ("rst.a.maddr", a_maddr, 32'h0);
    chk ("rst.a.cnt",   a_cnt,   32'h0);
    chk ("rst.b.cnt",   {28'd0, b_cnt}, 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table (expected values are for dut_a)
  typedef struct {
    bit          fr, st, br;
    logic [31:0] tgt;
    bit          tr;
    logic [31:0] vec;
    logic [31:0] e_pc;
    bit          e_valid, e_mis;
    logic [31:0] e_maddr, e_cnt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    //          fr st br tgt        tr vec          pc           v  m  maddr        cnt
    tbl[0]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h0,      1, 0, 32'h0,     32'd0}; // boot
    tbl[1]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h4,      1, 0, 32'h0,     32'd1};
    tbl[2]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h8,      1, 0, 32'h0,     32'd2};
    tbl[3]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'hC,      1, 0, 32'h0,     32'd3};
    tbl[4]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h10,     1, 0, 32'h0,     32'd4};
    tbl[5]  = '{0, 0, 0, 32'h0,     0, 32'h0,     32'h10,     1, 0, 32'h0,     32'd4}; // no ready
    tbl[6]  = '{0, 0, 0, 32'h0,     0, 32'h0,     32'h10,     1, 0, 32'h0,     32'd4};
    tbl[7]  = '{1, 1, 0, 32'h0,     0, 32'h0,     32'h10,     1, 0, 32'h0,     32'd4}; // stall
    tbl[8]  = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h14,     1, 0, 32'h0,     32'd5};
    tbl[9]  = '{0, 1, 1, 32'h200,   0, 32'h0,     32'h14,     1, 0, 32'h0,     32'd5}; // br under stall
    tbl[10] = '{0, 1, 1, 32'h200,   1, 32'h803,   32'h800,    1, 0, 32'h0,     32'd5}; // trap wins
    tbl[11] = '{0, 0, 1, 32'h300,   0, 32'h0,     32'h300,    1, 0, 32'h0,     32'd5}; // br, not accepted
    tbl[12] = '{1, 0, 1, 32'h400,   0, 32'h0,     32'h400,    1, 0, 32'h0,     32'd6};
    tbl[13] = '{1, 0, 0, 32'h0,     1, 32'h500,   32'h500,    1, 0, 32'h0,     32'd7}; // trap + accept
    tbl[14] = '{0, 0, 1, 32'h202,   0, 32'h0,     32'h500,    0, 1, 32'h202,   32'd7}; // misalign
    tbl[15] = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h500,    0, 0, 32'h202,   32'd7}; // halted
    tbl[16] = '{1, 0, 1, 32'h600,   0, 32'h0,     32'h500,    0, 0, 32'h202,   32'd7};
    tbl[17] = '{0, 0, 0, 32'h0,     1, 32'h1000,  32'h1000,   1, 0, 32'h202,   32'd7}; // trap exits
    tbl[18] = '{1, 0, 0, 32'h0,     0, 32'h0,     32'h1004,   1, 0, 32'h202,   32'd8};
  end

  initial begin
    logic [31:0] tgt;
    #0;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      idle_inputs();
      fetch_ready = tbl[i].fr; stall = tbl[i].st; br_taken = tbl[i].br;
      br_target = tbl[i].tgt; trap = tbl[i].tr; trap_vec = tbl[i].vec;
      tick();
      chk ($sformatf("tbl%0d.pc", i),    a_pc,    tbl[i].e_pc);
      chk1($sformatf("tbl%0d.valid", i), a_valid, tbl[i].e_valid);
      chk1($sformatf("tbl%0d.mis", i),   a_mis,   tbl[i].e_mis);
      chk ($sformatf("tbl%0d.maddr", i), a_maddr, tbl[i].e_maddr);
      chk ($sformatf("tbl%0d.cnt", i),   a_cnt,   tbl[i].e_cnt);
    end

    // Compressed stepping on dut_b from 0x100.
    idle_inputs(); trap = 1'b1; trap_vec = 32'h100;
    tick();
    chk("cmp.b.start", b_pc, 32'h100);
    idle_inputs(); fetch_ready = 1'b1; inst_comp = 1'b1;
    tick();
    chk("cmp.b.pc1", b_pc, 32'h102);
    inst_comp = 1'b0;
    #1;
    chk("cmp.b.seq", b_seq, 32'h106);
    tick();
    chk("cmp.b.pc2", b_pc, 32'h106);
    inst_comp = 1'b1;
    tick();
    chk("cmp.b.pc3", b_pc, 32'h108);
    chk("cmp.a.pc3", a_pc, 32'h10C);

    // Address wrap at the top of the space.
    idle_inputs(); trap = 1'b1; trap_vec = 32'hFFFF_FFFF;
    tick();
    chk("wrap.a.top", a_pc, 32'hFFFF_FFFC);
    idle_inputs(); fetch_ready = 1'b1;
    tick();
    chk("wrap.a.pc", a_pc, 32'h0);

    // Counter wrap: 17 accepts on a 4-bit counter leaves 1.
    do_reset();
    tick();
    fetch_ready = 1'b1;
    repeat (17) tick();
    chk("cnt.b.wrap", {28'd0, b_cnt}, 32'd1);
    chk("cnt.a.17",   a_cnt,          32'd17);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk ("arst.a.pc",    a_pc,    32'h0);
    chk1("arst.a.valid", a_valid, 1'b0);
    chk ("arst.a.cnt",   a_cnt,   32'h0);
    chk ("arst.b.pc",    b_pc,    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    model_reset();

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      fetch_ready = ($urandom_range(0, 9) < 7);
      stall       = ($urandom_range(0, 9) < 2);
      br_taken    = ($urandom_range(0, 9) < 2);
      trap        = ($urandom_range(0, 19) == 0);
      inst_comp   = ($urandom_range(0, 1) == 1);
      tgt = $urandom;
      if ($urandom_range(0, 2) != 0) tgt[0] = 1'b0;
      if ($urandom_range(0, 2) != 0) tgt[1] = 1'b0;
      br_target = tgt;
      trap_vec  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
